// File: rtl/seven_segment_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan_driver_if
// Description : Bundle of control inputs and display pins for the scanned
//               seven-segment driver.
//               master : source of the display value and mode controls
//               slave  : the scan driver
//               Signals: load, digits_in[4*NUM_DIGITS], hex_mode, enable
//                        (master -> slave), seg_n[7], an_n[NUM_DIGITS]
//                        (slave -> master).
// Revision    : 1.0 - initial release
// ============================================================================
interface seven_segment_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    hex_mode;
    logic                    enable;
    logic [6:0]              seg_n;
    logic [NUM_DIGITS-1:0]   an_n;

    modport master (
        output load,
        output digits_in,
        output hex_mode,
        output enable,
        input  seg_n,
        input  an_n
    );

    modport slave (
        input  load,
        input  digits_in,
        input  hex_mode,
        input  enable,
        output seg_n,
        output an_n
    );
endinterface
`default_nettype wire

// File: rtl/seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan_driver
// Description : Latches NUM_DIGITS packed nibbles and time-multiplexes them
//               onto a shared active-low segment bus with one-hot active-low
//               digit selects (common-anode display).
//               Ports : clk, rst (async, active high)
//                       bus (slave modport): load, digits_in, hex_mode,
//                       enable in; seg_n[6:0] (bit0=a..bit6=g), an_n out.
//               Build option: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank
//               leading zero digits (digit 0 is never blanked).
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  wire                          clk,
    input  wire                          rst,
    seven_segment_scan_driver_if.slave   bus
);

    localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0] c_presc_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [6:0]         c_seg_off    = 7'b1111111;

    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [c_cnt_w-1:0]      r_presc;
    logic [c_idx_w-1:0]      r_idx;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic                    w_terminal;
    logic [3:0]              w_nibble;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_an_next;
    logic [6:0]              w_seg_next;

    // Segment patterns, bit order g..a, active low.
    function automatic logic [6:0] f_decode(input logic [3:0] code, input logic hex);
        logic [6:0] v_seg;
        case (code)
            4'h0:    v_seg = 7'b1000000;
            4'h1:    v_seg = 7'b1111001;
            4'h2:    v_seg = 7'b0100100;
            4'h3:    v_seg = 7'b0110000;
            4'h4:    v_seg = 7'b0011001;
            4'h5:    v_seg = 7'b0010010;
            4'h6:    v_seg = 7'b0000010;
            4'h7:    v_seg = 7'b1111000;
            4'h8:    v_seg = 7'b0000000;
            4'h9:    v_seg = 7'b0010000;
            4'hA:    v_seg = hex ? 7'b0001000 : c_seg_off;
            4'hB:    v_seg = hex ? 7'b0000011 : c_seg_off;
            4'hC:    v_seg = hex ? 7'b1000110 : c_seg_off;
            4'hD:    v_seg = hex ? 7'b0100001 : c_seg_off;
            4'hE:    v_seg = hex ? 7'b0000110 : c_seg_off;
            default: v_seg = hex ? 7'b0001110 : c_seg_off;
        endcase
        return v_seg;
    endfunction

    assign w_terminal = (r_presc == c_presc_last);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit; a digit is blanked while
    // every nibble from the top down to it is zero. Digit 0 stays lit.
    always_comb begin : p_lz_mask
        logic v_run;
        v_run     = 1'b1;
        w_lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run        = v_run && (r_digits[i*4 +: 4] == 4'h0);
            w_lz_mask[i] = v_run;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    // Select the nibble and anode of the currently scanned digit.
    always_comb begin
        w_nibble  = '0;
        w_blank   = 1'b0;
        w_an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_idx_w'(i)) begin
                w_nibble     = r_digits[i*4 +: 4];
                w_blank      = w_lz_mask[i];
                w_an_next[i] = 1'b0;
            end
        end
        if (!bus.enable) begin
            w_an_next = '1;
        end
    end

    always_comb begin
        w_seg_next = f_decode(w_nibble, bus.hex_mode);
        if (!bus.enable || w_blank) begin
            w_seg_next = c_seg_off;
        end
    end

    // Pins are registered from the pre-edge index/register, so a digit
    // selected at edge k appears on the pins at edge k+1 and stays for
    // REFRESH_DIV cycles, matching the prescaler period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits <= '0;
            r_presc  <= '0;
            r_idx    <= '0;
            r_seg    <= c_seg_off;
            r_an     <= '1;
        end else begin
            if (bus.load) begin
                r_digits <= bus.digits_in;
            end
            if (w_terminal) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
            end else begin
                r_presc <= r_presc + c_cnt_w'(1);
            end
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign bus.seg_n = r_seg;
    assign bus.an_n  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scan_driver
// Description : Self-checking bench for seven_segment_scan_driver with
//               NUM_DIGITS=4, REFRESH_DIV=4. Table-driven decode vectors plus
//               directed sequences for reset, mode switch, enable gap and
//               load coinciding with a digit advance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    localparam logic [6:0] OFF = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_segment_scan_driver_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [15:0] digits;
        logic        hex;
        logic        en;
        int          dig;
        logic [6:0]  seg;
    } vec_t;

    vec_t vecs[48];
    int   nv     = 0;
    int   npass  = 0;
    int   ntotal = 0;
    int   ncyc   = 0;   // edges since the last reset release

    task automatic add(input logic [15:0] d, input logic h, input logic e,
                       input int dg, input logic [6:0] s);
        vecs[nv] = '{d, h, e, dg, s};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    // Digit shown on the pins right after edge n (n counted from release).
    function automatic int sel(input int n);
        return ((n - 1) / RD) % ND;
    endfunction

    function automatic logic [3:0] an_of(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    // Advance to the first pin cycle of digit d (always at least one edge).
    task automatic goto(input int d);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (sel(ncyc) != d && k < 40);
    endtask

    logic [6:0] af0c_hex [4];

    initial begin
        af0c_hex[0] = 7'b1000110;
        af0c_hex[1] = 7'b1000000;
        af0c_hex[2] = 7'b0001110;
        af0c_hex[3] = 7'b0001000;

        // ---------------- vector table ----------------
        add(16'h1234, 1'b0, 1'b1, 0, 7'b0011001);
        add(16'h1234, 1'b0, 1'b1, 1, 7'b0110000);
        add(16'h1234, 1'b0, 1'b1, 2, 7'b0100100);
        add(16'h1234, 1'b0, 1'b1, 3, 7'b1111001);
        add(16'hAF0C, 1'b1, 1'b1, 0, 7'b1000110);
        add(16'hAF0C, 1'b1, 1'b1, 1, 7'b1000000);
        add(16'hAF0C, 1'b1, 1'b1, 2, 7'b0001110);
        add(16'hAF0C, 1'b1, 1'b1, 3, 7'b0001000);
        add(16'hAF0C, 1'b0, 1'b1, 0, OFF);
        add(16'hAF0C, 1'b0, 1'b1, 1, 7'b1000000);
        add(16'hAF0C, 1'b0, 1'b1, 2, OFF);
        add(16'hAF0C, 1'b0, 1'b1, 3, OFF);
        add(16'h5678, 1'b0, 1'b1, 0, 7'b0000000);
        add(16'h5678, 1'b0, 1'b1, 1, 7'b1111000);
        add(16'h5678, 1'b0, 1'b1, 2, 7'b0000010);
        add(16'h5678, 1'b0, 1'b1, 3, 7'b0010010);
        add(16'h90BE, 1'b1, 1'b1, 0, 7'b0000110);
        add(16'h90BE, 1'b1, 1'b1, 1, 7'b0000011);
        add(16'h90BE, 1'b1, 1'b1, 2, 7'b1000000);
        add(16'h90BE, 1'b1, 1'b1, 3, 7'b0010000);
        add(16'hD000, 1'b1, 1'b1, 3, 7'b0100001);
        add(16'hD000, 1'b1, 1'b1, 0, 7'b1000000);
        add(16'h1234, 1'b0, 1'b0, 1, OFF);
        add(16'h0050, 1'b0, 1'b1, 3, LZ ? OFF : 7'b1000000);
        add(16'h0050, 1'b0, 1'b1, 2, LZ ? OFF : 7'b1000000);
        add(16'h0050, 1'b0, 1'b1, 1, 7'b0010010);
        add(16'h0050, 1'b0, 1'b1, 0, 7'b1000000);
        add(16'h0000, 1'b0, 1'b1, 0, 7'b1000000);
        add(16'h0000, 1'b0, 1'b1, 1, LZ ? OFF : 7'b1000000);
        add(16'h0000, 1'b0, 1'b1, 3, LZ ? OFF : 7'b1000000);

        // ---------------- reset state ----------------
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.hex_mode  = 1'b0;
        bus.enable    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_seg", bus.seg_n, OFF);
        chk("reset_an", bus.an_n, 4'hF);
        rst  = 1'b0;
        ncyc = 0;

        // ---------------- table ----------------
        for (int i = 0; i < nv; i++) begin
            bus.digits_in = vecs[i].digits;
            bus.hex_mode  = vecs[i].hex;
            bus.enable    = vecs[i].en;
            bus.load      = 1'b1;
            tick();
            bus.load      = 1'b0;
            goto(vecs[i].dig);
            chk($sformatf("vec%0d_seg", i), bus.seg_n, vecs[i].seg);
            chk($sformatf("vec%0d_an", i), bus.an_n,
                vecs[i].en ? an_of(vecs[i].dig) : 4'hF);
        end

        // ---------------- hex_mode switch latency ----------------
        bus.enable    = 1'b1;
        bus.hex_mode  = 1'b1;
        bus.digits_in = 16'hAF0C;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
        goto(0);
        chk("hexsw_before", bus.seg_n, 7'b1000110);
        bus.hex_mode = 1'b0;
        tick();
        chk("hexsw_after_seg", bus.seg_n, OFF);
        chk("hexsw_after_an", bus.an_n, 4'b1110);

        // ---------------- enable gap, no phase slip ----------------
        bus.hex_mode = 1'b1;
        goto(1);
        tick();
        bus.enable = 1'b0;
        tick();
        chk("en_dark_seg", bus.seg_n, OFF);
        chk("en_dark_an", bus.an_n, 4'hF);
        repeat (5) tick();
        chk("en_still_dark", bus.an_n, 4'hF);
        bus.enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("en_resume_an%0d", k), bus.an_n, an_of(sel(ncyc)));
            chk($sformatf("en_resume_seg%0d", k), bus.seg_n, af0c_hex[sel(ncyc)]);
        end

        // ---------------- load on the 0->1 advance edge ----------------
        bus.hex_mode  = 1'b0;
        bus.digits_in = 16'h0009;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
        for (int k = 0; k < 20 && ((ncyc + 1) % (RD * ND)) != RD; k++) tick();
        bus.digits_in = 16'h0090;
        bus.load      = 1'b1;
        tick();
        bus.load      = 1'b0;
        chk("adv_old_d0_seg", bus.seg_n, 7'b0010000);
        chk("adv_old_d0_an", bus.an_n, 4'b1110);
        tick();
        chk("adv_new_d1_seg", bus.seg_n, 7'b0010000);
        chk("adv_new_d1_an", bus.an_n, 4'b1101);

        // ---------------- async reset mid-scan ----------------
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_seg", bus.seg_n, OFF);
        chk("midrst_an", bus.an_n, 4'hF);
        tick();
        chk("midrst_hold_an", bus.an_n, 4'hF);
        rst  = 1'b0;
        ncyc = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("scan_an%0d", k), bus.an_n, an_of(sel(ncyc)));
            chk($sformatf("scan_seg%0d", k), bus.seg_n,
                (sel(ncyc) == 0 || !LZ) ? 7'b1000000 : OFF);
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
- Parametrised multi-digit successor to the team's single-digit seven-segment decoder.
- Latches a packed NUM_DIGITS x 4-bit value and time-multiplexes it onto one shared active-low segment bus.
- Adds a refresh prescaler, one-hot digit-select scanning, a hex/decimal mode, and a global display enable.
- Sits between datapath counters/registers and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles each digit stays selected; legal minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  when high at a clk edge, digits_in is captured into the display register.
- digits_in  input  4*NUM_DIGITS  packed BCD/hex nibbles; bits [3:0] are digit 0 (rightmost).
- hex_mode  input  1  1: codes 10-15 display A,b,C,d,E,F; 0: codes 10-15 display blank.
- enable  input  1  0: display dark; scanning continues.
- seg_n  output  7  active-low segments, bit0=a … bit6=g.
- an_n  output  NUM_DIGITS  active-low one-hot digit select; bit i selects digit i.

Behaviour:
- Reset (async assert, any cycle, including mid-scan) forces:
  - display register = 0, prescaler = 0, digit index = 0;
  - seg_n = 7'b1111111, an_n = all ones.
- Prescaler counts 0..REFRESH_DIV-1 and wraps. On the terminal count, the digit index advances: 0,1,…,NUM_DIGITS-1, then wraps to 0.
- REFRESH_DIV=1: index advances every cycle. NUM_DIGITS=1: index is held at 0.
- seg_n and an_n are registered, with 1-cycle latency from index/register/mode/enable to pins.
  - Each digit is driven for exactly REFRESH_DIV consecutive cycles.
  - an_n has exactly one zero whenever enable=1 and not in reset.
- load: the display register captures digits_in on the edge where load=1. The new value appears on the pins on the next edge at which its digit is selected.
  - load and index advance on the same edge both take effect; the newly selected digit uses the new data.
  - load held high continuously tracks digits_in every cycle.
- Decode table (seg_n, g..a order):
  - Digits: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - hex_mode=1: A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - hex_mode=0: codes 10-15 give 1111111, with the anode still driven.
- hex_mode and enable are sampled every cycle and take effect with 1-cycle latency; no resync of the scan is performed.
- enable=0: seg_n=1111111 and an_n=all ones on the next edge. Prescaler and index keep running, so re-enabling resumes at the current scan position.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Zero nibbles from digit NUM_DIGITS-1 downward, up to the first nonzero nibble, display 1111111.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - Blanking is computed from the display register, not digits_in.
  - The anode of a blanked digit is still driven, keeping scan timing unchanged.
- Not defined: all digits are decoded as-is, and leading zeros show "0".

Test Plan:
- Reset: assert rst mid-scan with REFRESH_DIV=4, NUM_DIGITS=4 -> same cycle, seg_n=1111111 and an_n=1111. After release, an_n sequence is 1110,1101,1011,0111,1110…, each held exactly 4 cycles.
- Load/decode: load digits_in=16'h1234, hex_mode=0 -> segment patterns are:
  - an_n=1110 → 0011001 (4);
  - an_n=1101 → 0110000 (3);
  - an_n=1011 → 0100100 (2);
  - an_n=0111 → 1111001 (1).
- Hex mode: load 16'hAF0C. hex_mode=1 -> digit0=1000110, digit1=1000000, digit2=0001110, digit3=0001000. Switching to hex_mode=0 -> digit0, digit2 and digit3 become 1111111 one cycle later.
- Enable: drop enable for 6 cycles mid-digit-1 -> pins dark 1 cycle later. After re-enable, the selected digit matches a free-running reference counter, with no phase slip.
- Simultaneous load+advance: load 16'h0009 on the edge where the index goes 0→1, then 16'h0090 -> digit1 shows 0010000 (9) on its first cycle.
- Macro defined: load 16'h0050 -> digits 3 and 2 are 1111111, digit1=0010010, digit0=1000000. Loading 16'h0000 -> only digit0 shows 1000000.
